inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
// Instruction-supply end of the core's instruction_in interface. Holds the PC and
// a word-addressed program store, and feeds one instruction per cycle to the
// single-cycle core. Applies the core's pc_source redirect, honours stall, and
// stops on EBREAK or on a fetch fault. A load port writes the program before start.
// PARAMETERS
// MEM_DEPTH   256           program store depth in 32-bit words (power of 2, >=4)
// RESET_PC    32'h00000000  PC after reset and after restart; word aligned
// NOP_INSTR   32'h00000013  word driven on instruction_out when not valid (addi x0,x0,0)
// PORTS
// clk            in   1   system clock, rising edge
// rst            in   1   asynchronous reset, active-low
// load_en        in   1   program write strobe; honoured only in IDLE
// load_addr      in   $clog2(MEM_DEPTH)  word index for the load write
// load_data      in   32  program word for the load write
// start          in   1   IDLE/HALT/FAULT -> RUN; 1-cycle pulse
// stall          in   1   hold PC and counters this cycle
// pc_source      in   1   from control: 1 = take branch_target, 0 = PC+4
// branch_target  in   32  redirect address from the core
// instruction_out out 32  instruction at pc_out (to core instruction_in)
// pc_out         out  32  current PC
// inst_valid     out  1   instruction_out is a real fetch (state RUN)
// halted         out  1   state HALT
// fault          out  1   state FAULT
// fault_pc       out  32  PC or target that caused the fault
// retire_count   out  32  count of instructions retired since start
// BEHAVIOUR
// - rst low (async): state=IDLE, pc=RESET_PC, fault_pc=0, retire_count=0. Program store is NOT cleared.
//   Outputs: inst_valid=0, halted=0, fault=0, instruction_out=NOP_INSTR.
// - States: IDLE, RUN, HALT, FAULT (one-hot or binary; encoding internal).
// - IDLE: if load_en, mem[load_addr] <= load_data at the edge.
//   start -> RUN with pc=RESET_PC, retire_count=0.
// - RUN: instruction_out = mem[pc[2+:AW]], combinational from the PC register.
//   This gives zero-latency fetch; the core executes it in the same cycle.
//   load_en is ignored. inst_valid=1.
// - RUN edge with stall=1: nothing changes. stall overrides pc_source, EBREAK and fault checks.
// - RUN edge with stall=0, evaluated in priority order:
//   1) instruction_out==32'h00100073 (EBREAK): state=HALT, pc holds, retire_count+1.
//   2) next = pc_source ? branch_target : pc+4 (32-bit, wraps at 2^32).
//      If next[1:0]!=0 or next[31:2]>=MEM_DEPTH: state=FAULT, fault_pc=next, pc holds, retire_count+1.
//   3) Otherwise pc=next, retire_count+1 (wraps at 2^32 with no flag).
// - pc==RESET_PC out of range at start: the first RUN cycle drives NOP_INSTR,
//   and the next non-stalled edge goes FAULT with fault_pc=pc.
// - Outside RUN: instruction_out=NOP_INSTR, inst_valid=0.
//   HALT: halted=1. FAULT: fault=1, fault_pc held.
// - start in HALT/FAULT: RUN at the next edge, pc=RESET_PC, retire_count=0, fault_pc kept.
//   load_en is ignored in HALT/FAULT; reset returns the block to IDLE for reloading.
// - start while in RUN: ignored.
// - start and load_en together in IDLE: the write happens and the state goes RUN at the same edge.
// - Reset asserted mid-RUN: IDLE immediately, outputs as above; program store contents retained.
// TESTING
// - Load 0x00500093,0x00100073 at words 0,1; start -> PC 0,4, then halted=1, retire_count=2.
// - Word 0=0x00000013; pc_source=1, target=0x10 at PC 0 -> pc_out=0x10 next cycle.
// - stall=1 for 3 cycles at PC 8 with pc_source=1 -> pc_out stays 8, retire_count frozen.
// - target=0x06 -> fault=1, fault_pc=0x06, inst_valid=0, instruction_out=0x00000013.
// - MEM_DEPTH=4, straight-line NOPs -> at PC 0xC: fault with fault_pc=0x10.
// - Reset low mid-RUN at PC 0x8 -> IDLE, pc_out=0; restart -> word 0 re-fetched intact.
// - HALT then start -> pc_out=RESET_PC, retire_count=0, halted=0.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Core-facing fetch bus of the instruction fetch unit.
// The core (master) steers the PC with stall/pc_source/branch_target and
// receives the fetched word, its PC and a valid flag from the fetch unit (slave).
interface inst_fetch_if;
  logic        stall;
  logic        pc_source;
  logic [31:0] branch_target;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        inst_valid;

  modport master (
    output stall,
    output pc_source,
    output branch_target,
    input  instruction_out,
    input  pc_out,
    input  inst_valid
  );

  modport slave (
    input  stall,
    input  pc_source,
    input  branch_target,
    output instruction_out,
    output pc_out,
    output inst_valid
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC and a word-addressed program store and
// hands one instruction per cycle to a single-cycle core. The fetch is
// combinational from the PC register so the core executes the word in the
// same cycle it is presented. Execution stops on EBREAK (HALT) or when the
// next PC would leave the program store or be misaligned (FAULT).
module inst_fetch_unit #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_load_addr,
  input  logic [31:0]                  i_load_data,
  input  logic                         i_start,
  inst_fetch_if.slave                  fetch,
  output logic                         o_halted,
  output logic                         o_fault,
  output logic [31:0]                  o_fault_pc,
  output logic [31:0]                  o_retire_count
);

  localparam int          AW           = $clog2(MEM_DEPTH);
  localparam logic [29:0] DEPTH_WORDS  = 30'(MEM_DEPTH);
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_faultPc;
  logic [31:0] r_retireCount;
  logic        r_instValid;
  logic        r_halted;
  logic        r_fault;

  logic [31:0] r_mem [MEM_DEPTH];

  logic [AW-1:0] w_fetchIdx;
  logic [31:0]   w_memWord;
  logic          w_pcInRange;
  logic [31:0]   w_pcPlus4;
  logic [31:0]   w_next;
  logic          w_nextInRange;
  logic [31:0]   w_fetchWord;
  logic          w_isEbreak;

  // Program store write port; only open while IDLE, never cleared by reset
  // so a program survives a reset and can simply be restarted.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_IDLE && i_load_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  assign w_fetchIdx  = r_pc[2 +: AW];
  assign w_memWord   = r_mem[w_fetchIdx];
  assign w_pcInRange = (r_pc[1:0] == 2'b00) && (r_pc[31:2] < DEPTH_WORDS);

  // Candidate next PC: sequential or redirected, with its legality check.
  assign w_pcPlus4     = r_pc + 32'd4;
  assign w_next        = fetch.pc_source ? fetch.branch_target : w_pcPlus4;
  assign w_nextInRange = (w_next[1:0] == 2'b00) && (w_next[31:2] < DEPTH_WORDS);

  // Zero-latency fetch: a real word only while running from a legal PC.
  always_comb begin
    w_fetchWord = NOP_INSTR;
    if (r_state == ST_RUN && w_pcInRange) begin
      w_fetchWord = w_memWord;
    end
  end

  assign w_isEbreak = (w_fetchWord == EBREAK_INSTR);

  // Control FSM: PC, retire counter, fault capture and registered status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_faultPc     <= '0;
      r_retireCount <= '0;
      r_instValid   <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT, ST_FAULT: begin
          if (i_start) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_retireCount <= '0;
            r_instValid   <= 1'b1;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!fetch.stall) begin
            if (!w_pcInRange) begin
              // Only reachable when RESET_PC itself lies outside the store.
              r_state     <= ST_FAULT;
              r_faultPc   <= r_pc;
              r_instValid <= 1'b0;
              r_fault     <= 1'b1;
            end else if (w_isEbreak) begin
              r_state       <= ST_HALT;
              r_retireCount <= r_retireCount + 32'd1;
              r_instValid   <= 1'b0;
              r_halted      <= 1'b1;
            end else if (!w_nextInRange) begin
              r_state       <= ST_FAULT;
              r_faultPc     <= w_next;
              r_retireCount <= r_retireCount + 32'd1;
              r_instValid   <= 1'b0;
              r_fault       <= 1'b1;
            end else begin
              r_pc          <= w_next;
              r_retireCount <= r_retireCount + 32'd1;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_instValid <= 1'b0;
          r_halted    <= 1'b0;
          r_fault     <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.instruction_out = w_fetchWord;
  assign fetch.pc_out          = r_pc;
  assign fetch.inst_valid      = r_instValid;
  assign o_halted              = r_halted;
  assign o_fault               = r_fault;
  assign o_fault_pc            = r_faultPc;
  assign o_retire_count        = r_retireCount;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: table-driven vectors on a 256-word
// instance plus hand-written sequences for reset and a 4-word instance.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] ADDI5 = 32'h0050_0093;

  typedef struct {
    logic        start;
    logic        loadEn;
    logic [7:0]  loadAddr;
    logic [31:0] loadData;
    logic        stall;
    logic        pcSource;
    logic [31:0] target;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic        expValid;
    logic        expHalted;
    logic        expFault;
    logic [31:0] expFaultPc;
    logic [31:0] expRetire;
  } vec_t;

  logic        clk;
  logic        rstN;

  logic        loadEn;
  logic [7:0]  loadAddr;
  logic [31:0] loadData;
  logic        start;
  logic        halted;
  logic        fault;
  logic [31:0] faultPc;
  logic [31:0] retireCount;

  logic        loadEnS;
  logic [1:0]  loadAddrS;
  logic [31:0] loadDataS;
  logic        startS;
  logic        haltedS;
  logic        faultS;
  logic [31:0] faultPcS;
  logic [31:0] retireCountS;

  int checks = 0;
  int errors = 0;

  vec_t tableA[$];
  vec_t tableB[$];

  inst_fetch_if fetchMain();
  inst_fetch_if fetchSmall();

  inst_fetch_unit #(.MEM_DEPTH(256)) dutMain (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_load_en      (loadEn),
    .i_load_addr    (loadAddr),
    .i_load_data    (loadData),
    .i_start        (start),
    .fetch          (fetchMain),
    .o_halted       (halted),
    .o_fault        (fault),
    .o_fault_pc     (faultPc),
    .o_retire_count (retireCount)
  );

  inst_fetch_unit #(.MEM_DEPTH(4)) dutSmall (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_load_en      (loadEnS),
    .i_load_addr    (loadAddrS),
    .i_load_data    (loadDataS),
    .i_start        (startS),
    .fetch          (fetchSmall),
    .o_halted       (haltedS),
    .o_fault        (faultS),
    .o_fault_pc     (faultPcS),
    .o_retire_count (retireCountS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic st, input logic ld, input logic [7:0] la, input logic [31:0] lw,
    input logic stl, input logic ps, input logic [31:0] tg,
    input logic [31:0] ePc, input logic [31:0] eIn, input logic eV,
    input logic eH, input logic eF, input logic [31:0] eFp, input logic [31:0] eR);
    vec_t v;
    v.start = st; v.loadEn = ld; v.loadAddr = la; v.loadData = lw;
    v.stall = stl; v.pcSource = ps; v.target = tg;
    v.expPc = ePc; v.expInstr = eIn; v.expValid = eV;
    v.expHalted = eH; v.expFault = eF; v.expFaultPc = eFp; v.expRetire = eR;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one vector for one clock edge; start/load are single-cycle pulses.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start                   = v.start;
    loadEn                  = v.loadEn;
    loadAddr                = v.loadAddr;
    loadData                = v.loadData;
    fetchMain.stall         = v.stall;
    fetchMain.pc_source     = v.pcSource;
    fetchMain.branch_target = v.target;
    @(posedge clk);
    #1;
    start  = 1'b0;
    loadEn = 1'b0;
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, " pc"},     fetchMain.pc_out, v.expPc);
    checkOutput({tag, " instr"},  fetchMain.instruction_out, v.expInstr);
    checkOutput({tag, " valid"},  32'(fetchMain.inst_valid), 32'(v.expValid));
    checkOutput({tag, " halted"}, 32'(halted), 32'(v.expHalted));
    checkOutput({tag, " fault"},  32'(fault), 32'(v.expFault));
    checkOutput({tag, " faultPc"}, faultPc, v.expFaultPc);
    checkOutput({tag, " retire"}, retireCount, v.expRetire);
  endtask

  task automatic loadWordMain(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    loadEn   = 1'b1;
    loadAddr = addr;
    loadData = data;
    @(posedge clk);
    #1;
    loadEn = 1'b0;
  endtask

  initial begin
    rstN = 1'b0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0; start = 1'b0;
    loadEnS = 1'b0; loadAddrS = '0; loadDataS = '0; startS = 1'b0;
    fetchMain.stall = 1'b0; fetchMain.pc_source = 1'b0; fetchMain.branch_target = '0;
    fetchSmall.stall = 1'b0; fetchSmall.pc_source = 1'b0; fetchSmall.branch_target = '0;

    // Reset state
    #3;
    checkVector("reset", mkVec(0,0,0,0, 0,0,0, 32'h0, NOP, 0, 0, 0, 32'h0, 32'h0));
    @(negedge clk);
    rstN = 1'b1;

    // Program A: addi then EBREAK; halt, restart, stall and priority checks
    loadWordMain(8'd0, ADDI5);
    loadWordMain(8'd1, EBRK);
    //                    st ld la lw  stl ps tg        pc     instr  v  h  f  fpc    ret
    tableA.push_back(mkVec(1, 0, 0, 0,  0, 0, 0,        32'h0, ADDI5, 1, 0, 0, 32'h0, 32'd0));
    tableA.push_back(mkVec(0, 0, 0, 0,  0, 0, 0,        32'h4, EBRK,  1, 0, 0, 32'h0, 32'd1));
    tableA.push_back(mkVec(0, 0, 0, 0,  0, 0, 0,        32'h4, NOP,   0, 1, 0, 32'h0, 32'd2));
    tableA.push_back(mkVec(0, 0, 0, 0,  0, 1, 32'h20,   32'h4, NOP,   0, 1, 0, 32'h0, 32'd2));
    tableA.push_back(mkVec(1, 0, 0, 0,  0, 0, 0,        32'h0, ADDI5, 1, 0, 0, 32'h0, 32'd0));
    tableA.push_back(mkVec(0, 0, 0, 0,  1, 0, 0,        32'h0, ADDI5, 1, 0, 0, 32'h0, 32'd0));
    tableA.push_back(mkVec(0, 0, 0, 0,  0, 0, 0,        32'h4, EBRK,  1, 0, 0, 32'h0, 32'd1));
    tableA.push_back(mkVec(0, 0, 0, 0,  1, 1, 32'h06,   32'h4, EBRK,  1, 0, 0, 32'h0, 32'd1));
    tableA.push_back(mkVec(0, 0, 0, 0,  0, 1, 32'h06,   32'h4, NOP,   0, 1, 0, 32'h0, 32'd2));
    foreach (tableA[i]) begin
      applyStimulus(tableA[i]);
      checkVector($sformatf("A%0d", i), tableA[i]);
    end

    // Reset from HALT returns to IDLE with cleared status
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkVector("rstHalt", mkVec(0,0,0,0, 0,0,0, 32'h0, NOP, 0, 0, 0, 32'h0, 32'h0));
    @(negedge clk);
    rstN = 1'b1;

    // Program B: word k = addi xk,x0,0 so every word is distinct; word 7 loaded with start
    loadWordMain(8'd0, 32'h0000_0013);
    loadWordMain(8'd1, 32'h0000_0093);
    loadWordMain(8'd2, 32'h0000_0113);
    loadWordMain(8'd3, 32'h0000_0193);
    loadWordMain(8'd4, 32'h0000_0213);
    loadWordMain(8'd5, 32'h0000_0293);
    loadWordMain(8'd6, 32'h0000_0313);
    //                    st ld la lw             stl ps tg          pc      instr         v  h  f  fpc      ret
    tableB.push_back(mkVec(1, 1, 7, 32'h0000_0393, 0, 0, 0,          32'h0,  32'h0000_0013, 1, 0, 0, 32'h0,   32'd0));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 1, 32'h10,     32'h10, 32'h0000_0213, 1, 0, 0, 32'h0,   32'd1));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 0, 32'h10,     32'h14, 32'h0000_0293, 1, 0, 0, 32'h0,   32'd2));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 1, 32'h08,     32'h8,  32'h0000_0113, 1, 0, 0, 32'h0,   32'd3));
    tableB.push_back(mkVec(0, 0, 0, 0,             1, 1, 32'h1C,     32'h8,  32'h0000_0113, 1, 0, 0, 32'h0,   32'd3));
    tableB.push_back(mkVec(0, 0, 0, 0,             1, 1, 32'h1C,     32'h8,  32'h0000_0113, 1, 0, 0, 32'h0,   32'd3));
    tableB.push_back(mkVec(0, 0, 0, 0,             1, 1, 32'h1C,     32'h8,  32'h0000_0113, 1, 0, 0, 32'h0,   32'd3));
    tableB.push_back(mkVec(0, 1, 0, 32'hDEADBEEF,  0, 1, 32'h1C,     32'h1C, 32'h0000_0393, 1, 0, 0, 32'h0,   32'd4));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 1, 32'h00,     32'h0,  32'h0000_0013, 1, 0, 0, 32'h0,   32'd5));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 1, 32'h06,     32'h0,  NOP,           0, 0, 1, 32'h6,   32'd6));
    tableB.push_back(mkVec(0, 1, 1, 32'hFFFFFFFF,  0, 0, 0,          32'h0,  NOP,           0, 0, 1, 32'h6,   32'd6));
    tableB.push_back(mkVec(1, 0, 0, 0,             0, 0, 0,          32'h0,  32'h0000_0013, 1, 0, 0, 32'h6,   32'd0));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 1, 32'h400,    32'h0,  NOP,           0, 0, 1, 32'h400, 32'd1));
    tableB.push_back(mkVec(1, 0, 0, 0,             0, 0, 0,          32'h0,  32'h0000_0013, 1, 0, 0, 32'h400, 32'd0));
    tableB.push_back(mkVec(0, 0, 0, 0,             0, 0, 0,          32'h4,  32'h0000_0093, 1, 0, 0, 32'h400, 32'd1));
    tableB.push_back(mkVec(1, 0, 0, 0,             0, 0, 0,          32'h8,  32'h0000_0113, 1, 0, 0, 32'h400, 32'd2));
    foreach (tableB[i]) begin
      applyStimulus(tableB[i]);
      checkVector($sformatf("B%0d", i), tableB[i]);
    end

    // Asynchronous reset mid-RUN at PC 8, then restart and re-fetch retained words
    #2;
    rstN = 1'b0;
    #1;
    checkVector("rstRun", mkVec(0,0,0,0, 0,0,0, 32'h0, NOP, 0, 0, 0, 32'h0, 32'h0));
    @(negedge clk);
    rstN = 1'b1;
    begin
      vec_t v;
      v = mkVec(1,0,0,0, 0,0,0, 32'h0, 32'h0000_0013, 1, 0, 0, 32'h0, 32'd0);
      applyStimulus(v);
      checkVector("restart", v);
      v = mkVec(0,0,0,0, 0,1,32'h1C, 32'h1C, 32'h0000_0393, 1, 0, 0, 32'h0, 32'd1);
      applyStimulus(v);
      checkVector("retained", v);
    end
    fetchMain.stall = 1'b1;

    // 4-word store: straight-line run off the end faults at PC 0xC with fault_pc 0x10
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      loadEnS   = 1'b1;
      loadAddrS = 2'(k);
      loadDataS = 32'(k * 128 + 32'h13);
      @(posedge clk);
      #1;
      loadEnS = 1'b0;
    end
    @(negedge clk);
    startS = 1'b1;
    @(posedge clk);
    #1;
    startS = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("S%0d pc", k), fetchSmall.pc_out, 32'(k * 4));
      checkOutput($sformatf("S%0d instr", k), fetchSmall.instruction_out, 32'(k * 128 + 32'h13));
      @(posedge clk);
      #1;
    end
    checkOutput("Send fault",   32'(faultS), 32'd1);
    checkOutput("Send faultPc", faultPcS, 32'h10);
    checkOutput("Send retire",  retireCountS, 32'd4);
    checkOutput("Send pc",      fetchSmall.pc_out, 32'hC);
    checkOutput("Send valid",   32'(fetchSmall.inst_valid), 32'd0);
    checkOutput("Send instr",   fetchSmall.instruction_out, NOP);
    checkOutput("Send halted",  32'(haltedS), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
